// File: rtl/vram_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_dma_arbiter
// Purpose  : Shares the VRAM CPU port between the MemoryUnit and a fill/copy
//            DMA engine that only uses cycles the MemoryUnit leaves idle.
// Revision : 1.0 - initial release
// ============================================================================
module vram_dma_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int WORDS  = 1056
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              mu_req,
    input  logic [ADDR_W-1:0] mu_addr,
    input  logic [DATA_W-1:0] mu_d,
    input  logic              mu_we,
    output logic [DATA_W-1:0] mu_q,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_d,
    output logic              vram_we,
    input  logic [DATA_W-1:0] vram_q,
    input  logic              dma_start,
    input  logic              dma_mode,
    input  logic [ADDR_W-1:0] dma_src,
    input  logic [ADDR_W-1:0] dma_dst,
    input  logic [ADDR_W-1:0] dma_len,
    input  logic [DATA_W-1:0] dma_pattern,
    input  logic              dma_abort,
    output logic              dma_busy,
    output logic              dma_done,
    output logic              dma_err
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_chk  = 3'd1;
    localparam logic [2:0] c_st_rd   = 3'd2;
    localparam logic [2:0] c_st_cap  = 3'd3;
    localparam logic [2:0] c_st_wr   = 3'd4;
    localparam logic [2:0] c_st_done = 3'd5;

    localparam logic [ADDR_W:0] c_words = (ADDR_W+1)'(WORDS);
    localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_last_addr;
    logic [DATA_W-1:0] r_pattern;
    logic [DATA_W-1:0] r_buf;
    logic [DATA_W-1:0] r_last_d;
    logic              r_mode;
    logic              r_err;

    logic              w_drive;
    logic              w_grant;
    logic              w_reject;
    logic              w_wr_fire;
    logic [ADDR_W:0]   w_idx_inc;
    logic [ADDR_W:0]   w_dst_end;
    logic [ADDR_W:0]   w_src_end;
    logic [ADDR_W-1:0] w_dma_addr;
    logic [DATA_W-1:0] w_dma_d;

    assign w_dst_end  = {1'b0, r_dst} + {1'b0, r_len};
    assign w_src_end  = {1'b0, r_src} + {1'b0, r_len};
    assign w_reject   = (w_dst_end > c_words) || (r_mode && (w_src_end > c_words));
    assign w_drive    = (r_state == c_st_rd) || (r_state == c_st_wr);
    assign w_grant    = w_drive && !mu_req;
    // Abort and a pending reset both suppress the write of the current cycle.
    assign w_wr_fire  = (r_state == c_st_wr) && w_grant && !dma_abort && nreset;
    assign w_idx_inc  = {1'b0, r_idx} + c_one;
    assign w_dma_addr = (r_state == c_st_rd) ? (r_src + r_idx) : (r_dst + r_idx);
    assign w_dma_d    = r_mode ? r_buf : r_pattern;

    assign mu_q     = vram_q;
    assign dma_busy = (r_state == c_st_chk) || (r_state == c_st_rd) ||
                      (r_state == c_st_cap) || (r_state == c_st_wr);
    assign dma_done = (r_state == c_st_done);
    assign dma_err  = (r_state == c_st_done) && r_err;

    always_comb begin
        vram_addr = r_last_addr;
        vram_d    = r_last_d;
        vram_we   = 1'b0;
        if (mu_req) begin
            vram_addr = mu_addr;
            vram_d    = mu_d;
            vram_we   = mu_we;
        end else if (w_drive) begin
            vram_addr = w_dma_addr;
            vram_d    = w_dma_d;
            vram_we   = w_wr_fire;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (dma_start) w_state_nxt = c_st_chk;
            c_st_chk: begin
                if (w_reject || (r_len == '0)) w_state_nxt = c_st_done;
                else if (r_mode)               w_state_nxt = c_st_rd;
                else                           w_state_nxt = c_st_wr;
            end
            c_st_rd:   if (w_grant) w_state_nxt = c_st_cap;
            // Read data is already on vram_q here, whoever owns the port now.
            c_st_cap:  w_state_nxt = c_st_wr;
            c_st_wr: begin
                if (w_grant) begin
                    if (w_idx_inc == {1'b0, r_len}) w_state_nxt = c_st_done;
                    else if (r_mode)                w_state_nxt = c_st_rd;
                    else                            w_state_nxt = c_st_wr;
                end
            end
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
        if (dma_busy && dma_abort) w_state_nxt = c_st_idle;
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state     <= c_st_idle;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_pattern   <= '0;
            r_mode      <= 1'b0;
            r_err       <= 1'b0;
            r_buf       <= '0;
            r_last_addr <= '0;
            r_last_d    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == c_st_idle) && dma_start) begin
                r_src     <= dma_src;
                r_dst     <= dma_dst;
                r_len     <= dma_len;
                r_pattern <= dma_pattern;
                r_mode    <= dma_mode;
                r_idx     <= '0;
            end
            if (r_state == c_st_chk) r_err <= w_reject;
            if (r_state == c_st_cap) r_buf <= vram_q;
            if (w_wr_fire)           r_idx <= r_idx + 1'b1;
            if (w_grant) begin
                r_last_addr <= w_dma_addr;
                r_last_d    <= w_dma_d;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_dma_arbiter
// Purpose  : Directed self-checking bench for vram_dma_arbiter with a VRAM
//            model and a transaction-level reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_dma_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int WORDS  = 1056;

    logic              clk = 1'b0;
    logic              nreset = 1'b0;
    logic              mu_req = 1'b0;
    logic [ADDR_W-1:0] mu_addr = '0;
    logic [DATA_W-1:0] mu_d = '0;
    logic              mu_we = 1'b0;
    logic [DATA_W-1:0] mu_q;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_d;
    logic              vram_we;
    logic [DATA_W-1:0] vram_q = '0;
    logic              dma_start = 1'b0;
    logic              dma_mode = 1'b0;
    logic [ADDR_W-1:0] dma_src = '0;
    logic [ADDR_W-1:0] dma_dst = '0;
    logic [ADDR_W-1:0] dma_len = '0;
    logic [DATA_W-1:0] dma_pattern = '0;
    logic              dma_abort = 1'b0;
    logic              dma_busy;
    logic              dma_done;
    logic              dma_err;

    vram_dma_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) u_dut (
        .clk(clk), .nreset(nreset),
        .mu_req(mu_req), .mu_addr(mu_addr), .mu_d(mu_d), .mu_we(mu_we), .mu_q(mu_q),
        .vram_addr(vram_addr), .vram_d(vram_d), .vram_we(vram_we), .vram_q(vram_q),
        .dma_start(dma_start), .dma_mode(dma_mode), .dma_src(dma_src), .dma_dst(dma_dst),
        .dma_len(dma_len), .dma_pattern(dma_pattern), .dma_abort(dma_abort),
        .dma_busy(dma_busy), .dma_done(dma_done), .dma_err(dma_err)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] init_word(int i);
        if (i < 3) return 32'(17 * (i + 1));
        return 32'(i * 16777619) ^ 32'hA5A5_0000;
    endfunction

    // VRAM with one-cycle registered read
    logic [DATA_W-1:0] mem     [0:WORDS-1];
    logic [DATA_W-1:0] ref_mem [0:WORDS-1];
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
        end else if (vram_we && (int'(vram_addr) < WORDS)) begin
            mem[vram_addr] <= vram_d;
        end
        vram_q <= (int'(vram_addr) < WORDS) ? mem[vram_addr] : '0;
    end

    int n_pass = 0;
    int n_total = 0;
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    int busy_n, done_cyc, err_cyc, run_s;
    int wr_addr[$];
    int wr_cyc[$];
    logic              p_rd = 1'b0;
    logic [ADDR_W-1:0] p_rd_addr = '0;

    always @(negedge clk) begin
        if (nreset) begin
            chk("mu_q_passthru", mu_q, vram_q);
            if (mu_req) begin
                chk("mux_addr", vram_addr, mu_addr);
                chk("mux_d", vram_d, mu_d);
                chk("mux_we", vram_we, mu_we);
            end else if (!dma_busy) begin
                chk("idle_we", vram_we, 1'b0);
            end
            if (p_rd) chk("mu_read_data", mu_q, ref_mem[p_rd_addr]);
            if (dma_err) chk("err_with_done", dma_done, 1'b1);
            if (vram_we && !mu_req) begin
                wr_addr.push_back(int'(vram_addr));
                wr_cyc.push_back(cyc);
            end
            if (dma_busy) busy_n++;
            if (dma_done && done_cyc < 0) done_cyc = cyc;
            if (dma_err && err_cyc < 0) err_cyc = cyc;
        end
        p_rd      = nreset && mu_req && !mu_we;
        p_rd_addr = mu_addr;
    end

    int mu_mode = 0;
    int mu_base = 0;
    bit mu_wrote = 1'b0;

    function automatic bit mu_busy(int c);
        case (mu_mode)
            1:       return (c >= mu_base) && (((c - mu_base) % 2) == 0);
            2:       return c == mu_base;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        dma_start = 1'b0;
        dma_abort = 1'b0;
        if (mu_busy(cyc)) begin
            mu_req = 1'b1;
            if ((mu_mode == 1) && !mu_wrote) begin
                mu_we = 1'b1; mu_addr = 14'd500; mu_d = 32'h0000_CAFE;
                ref_mem[500] = 32'h0000_CAFE;
                mu_wrote = 1'b1;
            end else begin
                mu_we = 1'b0;
                mu_addr = (mu_mode == 1) ? 14'd500 : 14'd2;
            end
        end else begin
            mu_req = 1'b0;
            mu_we  = 1'b0;
        end
    endtask

    // Done cycle from the rules: fill needs one free slot per word; copy needs
    // a free read slot, one capture cycle, then a free write slot per word.
    function automatic int predict(int s, bit mode, int len, bit rej);
        int c;
        if (rej || len == 0) return s + 2;
        c = s + 2;
        for (int i = 0; i < len; i++) begin
            while (mu_busy(c)) c++;
            c++;
            if (mode) begin
                c++;
                while (mu_busy(c)) c++;
                c++;
            end
        end
        return c;
    endfunction

    function automatic int mismatches();
        int n = 0;
        for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    task automatic start_dma(bit mode, int src, int dst, int len, logic [31:0] pat,
                             int mm, int off);
        wr_addr.delete(); wr_cyc.delete();
        busy_n = 0; done_cyc = -1; err_cyc = -1;
        dma_mode = mode; dma_src = ADDR_W'(src); dma_dst = ADDR_W'(dst);
        dma_len = ADDR_W'(len); dma_pattern = pat; dma_start = 1'b1;
        run_s = cyc;
        mu_mode = mm; mu_base = cyc + off; mu_wrote = 1'b0;
    endtask

    task automatic run_dma(bit mode, int src, int dst, int len, logic [31:0] pat,
                           int mm, int off, bit rej);
        int exp_done;
        start_dma(mode, src, dst, len, pat, mm, off);
        for (int n = 0; n < 200 && done_cyc < 0; n++) tick();
        if (done_cyc < 0) chk("done_timeout", 1'b0, 1'b1);
        exp_done = predict(run_s, mode, len, rej);
        chk("done_cycle", done_cyc, exp_done);
        chk("busy_cycles", busy_n, exp_done - run_s - 1);
        chk("err_flag", err_cyc >= 0, rej);
        if (rej) chk("err_coincident", err_cyc, done_cyc);
        chk("write_count", wr_addr.size(), rej ? 0 : len);
        for (int i = 0; i < wr_addr.size() && i < len; i++)
            chk("write_addr", wr_addr[i], dst + i);
        if (!rej)
            for (int i = 0; i < len; i++)
                ref_mem[dst + i] = mode ? ref_mem[src + i] : pat;
        mu_mode = 0;
        tick(); tick();
        chk("mem_image", mismatches(), 0);
    endtask

    task automatic run_interrupted(bit use_reset);
        start_dma(1'b0, 0, 400, 20, 32'h1234_5678, 0, 0);
        for (int n = 0; n < 60 && wr_addr.size() < 5; n++) tick();
        if (use_reset) nreset = 1'b0;
        else           dma_abort = 1'b1;
        tick(); tick();
        if (use_reset) begin
            chk("rst_busy", dma_busy, 1'b0);
            chk("rst_done", dma_done, 1'b0);
            chk("rst_err", dma_err, 1'b0);
            chk("rst_we", vram_we, 1'b0);
            chk("rst_addr", vram_addr, 0);
            chk("rst_d", vram_d, 0);
            nreset = 1'b1;
        end
        for (int n = 0; n < 6; n++) tick();
        chk("intr_writes", wr_addr.size(), 5);
        chk("intr_busy", dma_busy, 1'b0);
        chk("intr_no_done", done_cyc, -1);
        for (int i = 0; i < 5; i++) ref_mem[400 + i] = 32'h1234_5678;
        chk("intr_mem_image", mismatches(), 0);
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        busy_n = 0; done_cyc = -1; err_cyc = -1; run_s = 0;
        tick(); tick(); tick();
        chk("reset_busy", dma_busy, 1'b0);
        chk("reset_done", dma_done, 1'b0);
        chk("reset_err", dma_err, 1'b0);
        chk("reset_we", vram_we, 1'b0);
        chk("reset_addr", vram_addr, 0);
        chk("reset_d", vram_d, 0);
        nreset = 1'b1;
        tick(); tick();

        run_dma(1'b0, 0, 16, 4, 32'hDEAD_BEEF, 0, 0, 1'b0);
        chk("fill4_done_lat", done_cyc - run_s, 6);
        chk("fill4_busy", busy_n, 5);
        chk("fill4_word", mem[19], 32'hDEAD_BEEF);

        run_dma(1'b1, 0, 100, 3, 32'h0, 0, 0, 1'b0);
        chk("copy3_done_lat", done_cyc - run_s, 11);
        chk("copy3_word", mem[101], 32'h22);

        run_dma(1'b0, 0, 200, 8, 32'h5A5A_A5A5, 1, 2, 1'b0);
        if (wr_cyc.size() == 8) chk("fill8_span", wr_cyc[7] - run_s - 1, 16);
        else                    chk("fill8_span_count", wr_cyc.size(), 8);
        chk("mu_write_landed", mem[500], 32'h0000_CAFE);

        run_dma(1'b1, 0, 300, 2, 32'h0, 2, 3, 1'b0);
        chk("cap_word0", mem[300], 32'h11);
        chk("cap_word1", mem[301], 32'h22);

        run_dma(1'b0, 0, 1050, 10, 32'hFFFF_FFFF, 0, 0, 1'b1);
        chk("reject_lat", done_cyc - run_s, 2);
        run_dma(1'b1, 1000, 0, 57, 32'h0, 0, 0, 1'b1);
        run_dma(1'b0, 0, 10, 0, 32'hFFFF_FFFF, 0, 0, 1'b0);
        chk("len0_lat", done_cyc - run_s, 2);

        run_interrupted(1'b0);
        run_interrupted(1'b1);
        run_dma(1'b0, 0, 600, 2, 32'h0BAD_F00D, 0, 0, 1'b0);

        run_dma(1'b1, 700, 702, 4, 32'h0, 0, 0, 1'b0);
        chk("overlap_705", mem[705], init_word(701));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vram_dma_arbiter.md
Name: vram_dma_arbiter

Overview:
- Shares the 32-bit VRAM CPU-side port (vram32/vram322 write path) between the MemoryUnit and an internal DMA engine.
- The DMA engine supports two modes: fill a VRAM range with a constant word, or copy a range within VRAM.
- The MemoryUnit always has priority. The DMA uses only the cycles in which the MemoryUnit is not accessing VRAM.
- The block sits between the MemoryUnit's vram32 CPU signals and the VRAM cpu port, on the clk domain.

Parameters:
- ADDR_W, 14, VRAM word address width.
- DATA_W, 32, VRAM word width.
- WORDS, 1056, number of valid VRAM words; used for range checking.

Ports:
- clk  in  1  system clock (25 MHz).
- nreset  in  1  synchronous reset, active low.
- mu_req  in  1  MemoryUnit is accessing VRAM this cycle (read or write).
- mu_addr  in  ADDR_W  MemoryUnit address.
- mu_d  in  DATA_W  MemoryUnit write data.
- mu_we  in  1  MemoryUnit write enable; qualified by mu_req.
- mu_q  out  DATA_W  read data to MemoryUnit; equals vram_q.
- vram_addr  out  ADDR_W  VRAM cpu port address.
- vram_d  out  DATA_W  VRAM cpu port write data.
- vram_we  out  1  VRAM cpu port write enable.
- vram_q  in  DATA_W  VRAM cpu port read data; valid one cycle after the address is presented.
- dma_start  in  1  one-cycle pulse that latches the configuration and starts a transfer.
- dma_mode  in  1  0 = fill, 1 = copy.
- dma_src  in  ADDR_W  copy source base address.
- dma_dst  in  ADDR_W  destination base address.
- dma_len  in  ADDR_W  number of words to transfer.
- dma_pattern  in  DATA_W  fill word.
- dma_abort  in  1  stops the active transfer.
- dma_busy  out  1  high while a transfer is active.
- dma_done  out  1  one-cycle pulse when a transfer completes or is rejected.
- dma_err  out  1  one-cycle pulse, coincident with dma_done, when the range is rejected.

Behaviour:
- Reset: when nreset is low at a clk edge:
  - state = IDLE.
  - dma_busy, dma_done, dma_err, vram_we = 0.
  - vram_addr = 0, vram_d = 0.
  - All counters and latched configuration registers are cleared.
  - Reset during a transfer abandons it: no further writes and no done pulse.
- Port mux is combinational:
  - If mu_req = 1: vram_addr = mu_addr, vram_d = mu_d, vram_we = mu_we.
  - Otherwise the DMA drives the port in RD/WR states.
  - Otherwise the port shows the last DMA address with vram_we = 0.
  - mu_q = vram_q at all times.
- Grant: the DMA holds the port in any cycle where mu_req = 0 and state is RD or WR. A DMA state with no grant holds and retries.
- Latched on dma_start in IDLE: src, dst, len, pattern, mode. The counter idx is set to 0.
- dma_start is ignored while dma_busy = 1.
- Range check at start, one cycle, state CHK:
  - Reject if dst + len > WORDS, or mode = 1 and src + len > WORDS.
  - Sums are computed at ADDR_W + 1 bits.
  - On reject: dma_done = 1 and dma_err = 1 for one cycle, no VRAM access, return to IDLE.
- len = 0: dma_done pulses one cycle after CHK, with no writes.
- States:
  - IDLE -> CHK on dma_start.
  - CHK -> DONE on reject or len = 0.
  - CHK -> WR in fill mode.
  - CHK -> RD in copy mode.
  - RD: drive address src + idx with we = 0. When granted -> CAP.
  - CAP: capture vram_q into the buffer unconditionally. The read data is valid this cycle even if mu_req = 1 now. -> WR.
  - WR: drive address dst + idx with vram_d = pattern (fill) or the buffer (copy), we = 1. When granted, idx = idx + 1.
    - If idx + 1 = len -> DONE.
    - Else -> WR (fill) or RD (copy).
  - DONE: dma_done = 1 for one cycle, dma_busy = 0 -> IDLE.
- dma_busy = 1 in CHK, RD, CAP and WR.
- Throughput with mu_req held low:
  - Fill: 1 word per cycle.
  - Copy: 1 word per 3 cycles.
- Overlapping copy (dst > src with the ranges overlapping): the copy proceeds ascending. The result is the defined ascending-copy result, with no correction applied.
- dma_abort:
  - Takes effect at the next edge when busy, and has priority over a grant in the same cycle: the write is not performed.
  - State -> IDLE, dma_busy = 0, no dma_done.
  - Ignored in IDLE.
- Simultaneous dma_abort and dma_start in IDLE: dma_start wins.

Test Plan:
- Fill, mu_req = 0, dst = 16, len = 4, pattern = 0xDEADBEEF:
  - Writes appear at addresses 16..19 on four consecutive cycles.
  - dma_done pulses one cycle after the last write.
  - dma_busy is high for 5 cycles.
- Copy, src = 0, dst = 100, len = 3, VRAM[0..2] = 0x11/0x22/0x33: VRAM[100..102] = 0x11/0x22/0x33 after 9 active cycles, then dma_done.
- Fill of len = 8 with mu_req high every other cycle, and a MemoryUnit write to address 500 = 0xCAFE in those cycles:
  - The MemoryUnit write lands, with no stall.
  - All 8 DMA writes complete in 16 cycles.
  - mu_q returns the correct data on MemoryUnit reads.
- Copy where mu_req = 1 in the CAP cycle: the captured word is still the source word, and the destination is correct.
- Range reject: dst = 1050, len = 10 -> dma_done and dma_err pulse together two cycles after start, with vram_we never asserted. len = 0 -> dma_done with dma_err = 0.
- Abort and reset: fill of len = 20 with dma_abort after 5 writes -> exactly 5 writes, dma_busy = 0, no dma_done. Repeating the same case with nreset low instead of abort -> all outputs 0 and the block accepts a new start.
